cci_mpf_shim_vtp_svc_arb: RTL



---
 rtl/cci_mpf_shim_vtp_svc_arb_if.sv | 55 +++++
 rtl/cci_mpf_shim_vtp_svc_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_vtp_svc_arb_if.sv
// VTP lookup types and the client/service bundle seen by the service arbiter.
package cci_mpf_shim_vtp_svc_arb_pkg;
    localparam int CCI_MPF_SHIM_VTP_MAX_SVC_REQS = 16;
    localparam int VTP_TAG_W = 4;
    localparam int VTP_VA_W  = 36;
    localparam int VTP_PA_W  = 36;

    typedef struct packed {
        logic [VTP_VA_W-1:0]  pageVA;
        logic [VTP_TAG_W-1:0] tag;
    } t_cci_mpf_shim_vtp_lookup_req;

    typedef struct packed {
        logic [VTP_PA_W-1:0]  pagePA;
        logic [VTP_TAG_W-1:0] tag;
        logic                 isBigPage;
    } t_cci_mpf_shim_vtp_lookup_rsp;
endpackage

interface cci_mpf_shim_vtp_svc_arb_if #(
    parameter int N_CLIENTS = 2
);
    import cci_mpf_shim_vtp_svc_arb_pkg::*;

    logic [N_CLIENTS-1:0]         c_lookupEn;
    t_cci_mpf_shim_vtp_lookup_req c_lookupReq [N_CLIENTS];
    logic [N_CLIENTS-1:0]         c_lookupRdy;
    logic [N_CLIENTS-1:0]         c_lookupRspValid;
    t_cci_mpf_shim_vtp_lookup_rsp c_lookupRsp [N_CLIENTS];
    logic [N_CLIENTS-1:0]         c_invalComplete;

    logic                         s_lookupEn;
    t_cci_mpf_shim_vtp_lookup_req s_lookupReq;
    logic                         s_lookupRdy;
    logic                         s_lookupRspValid;
    t_cci_mpf_shim_vtp_lookup_rsp s_lookupRsp;
    logic                         s_invalComplete;
    logic                         errBadRsp;

    // Arbiter side
    modport slave (
        input  c_lookupEn, c_lookupReq, c_invalComplete,
               s_lookupRdy, s_lookupRspValid, s_lookupRsp,
        output c_lookupRdy, c_lookupRspValid, c_lookupRsp,
               s_lookupEn, s_lookupReq, s_invalComplete, errBadRsp
    );

    // Clients plus service (environment side)
    modport master (
        output c_lookupEn, c_lookupReq, c_invalComplete,
               s_lookupRdy, s_lookupRspValid, s_lookupRsp,
        input  c_lookupRdy, c_lookupRspValid, c_lookupRsp,
               s_lookupEn, s_lookupReq, s_invalComplete, errBadRsp
    );
endinterface

// File: rtl/cci_mpf_shim_vtp_svc_arb.sv
// Shares one VTP translation service among N_CLIENTS shims: per-client 2-deep
// request buffers, round-robin issue, service tag pool, out-of-order return.
// The interface instance must be built with the same N_CLIENTS.
module cci_mpf_shim_vtp_svc_arb
    import cci_mpf_shim_vtp_svc_arb_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int N_TAGS    = CCI_MPF_SHIM_VTP_MAX_SVC_REQS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    cci_mpf_shim_vtp_svc_arb_if.slave     vtp
);
    localparam int CW = $clog2(N_CLIENTS);

    t_cci_mpf_shim_vtp_lookup_req r_fifo [N_CLIENTS][2];
    logic [N_CLIENTS-1:0]         r_wr_ptr;
    logic [N_CLIENTS-1:0]         r_rd_ptr;
    logic [1:0]                   r_cnt [N_CLIENTS];
    logic [CW-1:0]                r_rr_ptr;

    logic [N_TAGS-1:0]            r_tag_valid;
    logic [CW-1:0]                r_tag_client [N_TAGS];
    logic [VTP_TAG_W-1:0]         r_tag_ctag [N_TAGS];

    logic [N_CLIENTS-1:0]         r_rsp_valid;
    t_cci_mpf_shim_vtp_lookup_rsp r_rsp;
    logic                         r_inval;
    logic                         r_err;

    logic [N_CLIENTS-1:0]         w_rdy;
    logic [N_CLIENTS-1:0]         w_nonempty;
    logic [N_CLIENTS-1:0]         w_enq;
    logic [N_CLIENTS-1:0]         w_deq;
    logic                         w_full;
    logic [VTP_TAG_W-1:0]         w_free_tag;
    logic [CW-1:0]                w_grant;
    logic                         w_any;
    logic                         w_issue;
    t_cci_mpf_shim_vtp_lookup_req w_head;
    logic [VTP_TAG_W-1:0]         w_rsp_tag;
    logic                         w_rsp_hit;
    logic                         w_rsp_bad;

    // Buffer status decoded from registered counts only
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_rdy[i]      = (r_cnt[i] != 2'd2);
            w_nonempty[i] = (r_cnt[i] != 2'd0);
        end
    end

    // Lowest-index unallocated service tag; descending scan so index 0 wins
    always_comb begin
        w_full     = 1'b1;
        w_free_tag = '0;
        for (int t = N_TAGS - 1; t >= 0; t--) begin
            if (!r_tag_valid[t]) begin
                w_full     = 1'b0;
                w_free_tag = VTP_TAG_W'(t);
            end
        end
    end

    // Round-robin grant: first non-empty client strictly after r_rr_ptr
    always_comb begin
        w_grant = r_rr_ptr;
        w_any   = 1'b0;
        for (int k = N_CLIENTS; k >= 1; k--) begin
            if (w_nonempty[CW'((int'(r_rr_ptr) + k) % N_CLIENTS)]) begin
                w_grant = CW'((int'(r_rr_ptr) + k) % N_CLIENTS);
                w_any   = 1'b1;
            end
        end
    end

    // Issue decision, dequeue/enqueue strobes and response classification
    always_comb begin
        w_issue   = vtp.s_lookupRdy & ~w_full & w_any;
        w_head    = r_fifo[w_grant][r_rd_ptr[w_grant]];
        w_enq     = vtp.c_lookupEn & w_rdy;
        w_deq     = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_deq[i] = w_issue & (w_grant == CW'(i));
        end
        w_rsp_tag = vtp.s_lookupRsp.tag;
        w_rsp_hit = vtp.s_lookupRspValid & (int'(w_rsp_tag) < N_TAGS) &
                    r_tag_valid[w_rsp_tag];
        w_rsp_bad = vtp.s_lookupRspValid & ~w_rsp_hit;
    end

    // FIFO pointers and counts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < N_CLIENTS; i++) r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (w_enq[i]) r_wr_ptr[i] <= ~r_wr_ptr[i];
                if (w_deq[i]) r_rd_ptr[i] <= ~r_rd_ptr[i];
                r_cnt[i] <= r_cnt[i] + 2'(w_enq[i]) - 2'(w_deq[i]);
            end
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_enq[i]) r_fifo[i][r_wr_ptr[i]] <= vtp.c_lookupReq[i];
        end
    end

    // Tag valid bits and arbitration pointer; free and alloc never collide
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag_valid <= '0;
            r_rr_ptr    <= CW'(N_CLIENTS - 1);
        end else begin
            if (w_rsp_hit) r_tag_valid[w_rsp_tag] <= 1'b0;
            if (w_issue) begin
                r_tag_valid[w_free_tag] <= 1'b1;
                r_rr_ptr                <= w_grant;
            end
        end
    end

    // Tag owner bookkeeping (data only)
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_client[w_free_tag] <= w_grant;
            r_tag_ctag[w_free_tag]   <= w_head.tag;
        end
    end

    // Response strobe, inval merge and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp_valid <= '0;
            r_inval     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_hit ? (N_CLIENTS'(1) << r_tag_client[w_rsp_tag]) : '0;
            r_inval     <= |vtp.c_invalComplete;
            r_err       <= r_err | w_rsp_bad;
        end
    end

    // Response payload with the client's original tag restored (data only)
    always_ff @(posedge clk) begin
        r_rsp.pagePA    <= vtp.s_lookupRsp.pagePA;
        r_rsp.tag       <= r_tag_ctag[w_rsp_tag];
        r_rsp.isBigPage <= vtp.s_lookupRsp.isBigPage;
    end

    // Output drive; payload is broadcast, only the strobe is per client
    always_comb begin
        vtp.c_lookupRdy      = w_rdy;
        vtp.c_lookupRspValid = r_rsp_valid;
        for (int i = 0; i < N_CLIENTS; i++) vtp.c_lookupRsp[i] = r_rsp;
        vtp.s_lookupEn         = w_issue;
        vtp.s_lookupReq.pageVA = w_head.pageVA;
        vtp.s_lookupReq.tag    = w_free_tag;
        vtp.s_invalComplete    = r_inval;
        vtp.errBadRsp          = r_err;
    end
endmodule
